// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle for the multi-cycle MIPS core.
// master = control FSM, slave = datapath/memory side.
interface multicycle_control_if #(
    parameter int COUNT_W = 16
);
    logic [5:0]         opcode;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         aluOP;
    logic [1:0]         pc_source;
    logic [3:0]         state;
    logic               retire;
    logic               illegal_op;
    logic [COUNT_W-1:0] instr_count;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write,
        output ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
        output alu_src_b, aluOP, pc_source, state, retire,
        output illegal_op, instr_count
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write,
        input  ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
        input  alu_src_b, aluOP, pc_source, state, retire,
        input  illegal_op, instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath, with retire counter.
// Define MCC_ILLEGAL_TRAP_EN to park the core on an unsupported opcode.
module multicycle_control #(
    parameter int COUNT_W = 16
) (
    input logic                 clk,
    input logic                 reset,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC     = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t             state, next_state;
    logic [COUNT_W-1:0] count;
    logic               retire_c;
    logic               illegal_c;
    logic               park;
    logic               is_r, is_lw, is_ls, is_beq, is_j, is_addi;

    assign is_r    = (bus.opcode == OP_R);
    assign is_lw   = (bus.opcode == OP_LW);
    assign is_ls   = is_lw || (bus.opcode == OP_SW);
    assign is_beq  = (bus.opcode == OP_BEQ);
    assign is_j    = (bus.opcode == OP_J);
    assign is_addi = (bus.opcode == OP_ADDI);

`ifdef MCC_ILLEGAL_TRAP_EN
    logic trapped;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            trapped <= 1'b0;
        else if (illegal_c)
            trapped <= 1'b1;
    end

    assign park = trapped;
`else
    assign park = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= FETCH;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (retire_c)
            count <= count + 1'b1;
    end

    always_comb begin
        next_state        = state;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.aluOP         = 2'b00;
        bus.pc_source     = 2'b00;
        retire_c          = 1'b0;
        illegal_c         = 1'b0;
        unique case (state)
            FETCH: begin
                bus.alu_src_b = 2'b01;
                // A trapped core stops issuing fetches until reset.
                if (!park) begin
                    bus.mem_read = 1'b1;
                    bus.ir_write = bus.mem_ready;
                    bus.pc_write = bus.mem_ready;
                    if (bus.mem_ready)
                        next_state = DECODE;
                end
            end
            DECODE: begin
                bus.alu_src_b = 2'b11;
                unique case (1'b1)
                    is_r:    next_state = EXEC;
                    is_ls:   next_state = MEM_ADDR;
                    is_beq:  next_state = BRANCH;
                    is_j:    next_state = JUMP;
                    is_addi: next_state = ADDI_EX;
                    default: begin
                        illegal_c  = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                next_state    = is_lw ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                if (bus.mem_ready)
                    next_state = MEM_WB;
            end
            MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                retire_c       = 1'b1;
                next_state     = FETCH;
            end
            MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                retire_c      = bus.mem_ready;
                if (bus.mem_ready)
                    next_state = FETCH;
            end
            EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.aluOP     = 2'b10;
                next_state    = R_WB;
            end
            R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                retire_c      = 1'b1;
                next_state    = FETCH;
            end
            BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.aluOP         = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'b01;
                retire_c          = 1'b1;
                next_state        = FETCH;
            end
            JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b10;
                retire_c      = 1'b1;
                next_state    = FETCH;
            end
            ADDI_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                next_state    = ADDI_WB;
            end
            ADDI_WB: begin
                bus.reg_write = 1'b1;
                retire_c      = 1'b1;
                next_state    = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

    assign bus.state       = state;
    assign bus.retire      = retire_c;
    assign bus.illegal_op  = illegal_c | park;
    assign bus.instr_count = count;
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction stream against an instruction-level model
// of the multi-cycle controller (sequence + per-state control word).
module tb_multicycle_control;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multicycle_control_if #(.COUNT_W(CW)) bus ();

    multicycle_control #(.COUNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [CW-1:0] model_cnt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] obs();
        return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.aluOP,
                bus.pc_source, bus.retire, bus.illegal_op};
    endfunction

    // Control word the datapath must see in each state.
    function automatic logic [17:0] exp_outs(input int st, input logic rdy,
                                             input logic bad, input logic prk);
        logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, ret, ill;
        logic [1:0] sb, op, ps;
        {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, ret, ill} = '0;
        sb = 2'b00; op = 2'b00; ps = 2'b00;
        case (st)
            0: begin
                sb = 2'b01;
                if (prk) ill = 1'b1;
                else begin mr = 1'b1; irw = rdy; pw = rdy; end
            end
            1: begin sb = 2'b11; ill = bad; end
            2: begin sa = 1'b1; sb = 2'b10; end
            3: begin mr = 1'b1; io = 1'b1; end
            4: begin rw = 1'b1; m2r = 1'b1; ret = 1'b1; end
            5: begin mw = 1'b1; io = 1'b1; ret = rdy; end
            6: begin sa = 1'b1; op = 2'b10; end
            7: begin rw = 1'b1; rd = 1'b1; ret = 1'b1; end
            8: begin sa = 1'b1; op = 2'b01; pwc = 1'b1; ps = 2'b01; ret = 1'b1; end
            9: begin pw = 1'b1; ps = 2'b10; ret = 1'b1; end
            10: begin sa = 1'b1; sb = 2'b10; end
            11: begin rw = 1'b1; ret = 1'b1; end
            default: ;
        endcase
        return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps, ret, ill};
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011,
                          6'b000100, 6'b000010, 6'b001000};
    endfunction

    // One clock of the model; called at a falling edge, returns at the next.
    task automatic step(input int st, input logic rdy, input logic [5:0] op,
                        input logic bad, input logic prk);
        logic [17:0] e;
        bus.mem_ready = rdy;
        bus.opcode    = op;
        #1;
        e = exp_outs(st, rdy, bad, prk);
        chk($sformatf("state@%0d", st), 32'(bus.state), 32'(st));
        chk($sformatf("outs@%0d", st), 32'(obs()), 32'(e));
        chk($sformatf("count@%0d", st), 32'(bus.instr_count), 32'(model_cnt));
        if (e[1]) model_cnt++;
        @(negedge clk);
    endtask

    function automatic logic [5:0] junk();
        return 6'($urandom);
    endfunction

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    function automatic int stalls();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    task automatic do_reset_check(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, "_state"}, 32'(bus.state), 32'd0);
        chk({tag, "_retire"}, 32'(bus.retire), 32'd0);
        chk({tag, "_count"}, 32'(bus.instr_count), 32'd0);
        chk({tag, "_memrd"}, 32'(bus.mem_read), 32'd1);
        chk({tag, "_illegal"}, 32'(bus.illegal_op), 32'd0);
        model_cnt = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_instr(input logic [5:0] op, input int fs,
                             input int ms, input bit abort);
        logic bad;
        bad = !legal(op);
        for (int i = 0; i < fs; i++) step(0, 1'b0, junk(), 1'b0, 1'b0);
        step(0, 1'b1, junk(), 1'b0, 1'b0);
        step(1, rnd(), op, bad, 1'b0);
        if (bad) begin
`ifdef MCC_ILLEGAL_TRAP_EN
            for (int i = 0; i < 4; i++) step(0, rnd(), junk(), 1'b0, 1'b1);
            do_reset_check("trap_rst");
`endif
        end else begin
            case (op)
                6'b000000: begin
                    step(6, rnd(), junk(), 1'b0, 1'b0);
                    step(7, rnd(), junk(), 1'b0, 1'b0);
                end
                6'b100011: begin
                    step(2, rnd(), op, 1'b0, 1'b0);
                    for (int i = 0; i < ms; i++) step(3, 1'b0, junk(), 1'b0, 1'b0);
                    step(3, 1'b1, junk(), 1'b0, 1'b0);
                    step(4, rnd(), junk(), 1'b0, 1'b0);
                end
                6'b101011: begin
                    step(2, rnd(), op, 1'b0, 1'b0);
                    if (abort) begin
                        step(5, 1'b0, junk(), 1'b0, 1'b0);
                        bus.mem_ready = 1'b0;
                        #3;
                        do_reset_check("abort_rst");
                    end else begin
                        for (int i = 0; i < ms; i++) step(5, 1'b0, junk(), 1'b0, 1'b0);
                        step(5, 1'b1, junk(), 1'b0, 1'b0);
                    end
                end
                6'b000100: step(8, rnd(), junk(), 1'b0, 1'b0);
                6'b000010: step(9, rnd(), junk(), 1'b0, 1'b0);
                default: begin
                    step(10, rnd(), junk(), 1'b0, 1'b0);
                    step(11, rnd(), junk(), 1'b0, 1'b0);
                end
            endcase
        end
    endtask

    logic [5:0] ops [6];
    logic [5:0] op;

    initial begin
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode    = 6'b000000;
        model_cnt     = '0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_state", 32'(bus.state), 32'd0);
            chk("rst_memrd", 32'(bus.mem_read), 32'd1);
            chk("rst_srcb", 32'(bus.alu_src_b), 32'd1);
            chk("rst_retire", 32'(bus.retire), 32'd0);
            chk("rst_count", 32'(bus.instr_count), 32'd0);
        end
        reset = 1'b0;

        run_instr(6'b000000, 0, 0, 1'b0);
        run_instr(6'b100011, 0, 2, 1'b0);
        run_instr(6'b000100, 0, 0, 1'b0);
        run_instr(6'b000010, 0, 0, 1'b0);
        run_instr(6'b111111, 0, 0, 1'b0);
        run_instr(6'b101011, 1, 1, 1'b0);
        run_instr(6'b001000, 2, 0, 1'b0);
        run_instr(6'b101011, 0, 0, 1'b1);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do op = junk(); while (legal(op));
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            run_instr(op, stalls(), stalls(),
                      (op == 6'b101011) && ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
